vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-003 The block SHALL have parameter FB_W, default 320, meaning frame-buffer width (2x horizontal scale).
REQ-004 The block SHALL have parameter FB_H, default 240, meaning frame-buffer height (2x vertical scale).
REQ-005 The block SHALL have parameter PIX_W, default 12, meaning pixel data width (4:4:4 RGB).
REQ-006 The block SHALL have ports: clk in 1, pixel clock, one cycle per pixel; reset in 1, synchronous active-high.
REQ-007 The block SHALL have ports: h_cnt in 10, v_cnt in 10, h_sync_in in 1, v_sync_in in 1; raw timing from the VGA timing generator.
REQ-008 The block SHALL have ports: cpu_req in 1, cpu_we in 1, cpu_addr in 17, cpu_wdata in PIX_W; writer/reader request, held stable until cpu_ack.
REQ-009 The block SHALL have ports: cpu_ack out 1, access issued; cpu_rvalid out 1, read data valid; cpu_rdata out PIX_W.
REQ-010 The block SHALL have ports: mem_addr out 17, mem_we out 1, mem_wdata out PIX_W, mem_rdata in PIX_W; single-port synchronous RAM, 1-cycle read latency.
REQ-011 The block SHALL have ports: rgb out PIX_W, h_sync out 1, v_sync out 1, frame_start out 1, drop_cnt out 8.

Function
REQ-012 A cycle SHALL be a display slot iff h_cnt < H_ACTIVE, v_cnt < V_ACTIVE and h_cnt[0] == 0; every other cycle SHALL be a CPU slot.
REQ-013 In a display slot the block SHALL register mem_addr = (v_cnt>>1)*FB_W + (h_cnt>>1), mem_we = 0, computed with shifts/adds only (y*256 + y*64 + x) at 17-bit width.
REQ-014 The display path SHALL have a fixed latency of 3: rgb for the pixel at (h_cnt, v_cnt) in cycle t appears in cycle t+3; odd pixels repeat the preceding even pixel.
REQ-015 rgb SHALL be 0 for any pixel outside the active area.
REQ-016 h_sync and v_sync SHALL equal h_sync_in and v_sync_in delayed by exactly 3 cycles.
REQ-017 CPU FSM states SHALL be IDLE and ACK; IDLE->ACK when cpu_req = 1 in a CPU slot; ACK->IDLE unconditionally after one cycle.
REQ-018 On IDLE->ACK the block SHALL register mem_addr/mem_we/mem_wdata from cpu_* and pulse cpu_ack high for exactly the cycle those values are on mem_*.
REQ-019 No grant SHALL occur in state ACK (one bubble); back-to-back CPU accesses SHALL therefore be at most one per 2 cycles.
REQ-020 A display slot SHALL always win over a pending cpu_req; the request stays pending with no ack.
REQ-021 Worst-case cpu_req-to-cpu_ack latency SHALL be 2 cycles.
REQ-022 For a granted read, cpu_rvalid SHALL pulse exactly 2 cycles after cpu_ack with cpu_rdata registered from mem_rdata; cpu_rdata holds until the next read.
REQ-023 A request with cpu_addr >= FB_W*FB_H SHALL be acked normally, SHALL drive mem_we = 0, SHALL produce no cpu_rvalid, and SHALL increment drop_cnt, saturating at 255.
REQ-024 frame_start SHALL pulse for one cycle when h_cnt == 0 and v_cnt == V_ACTIVE (start of vertical blank).
REQ-025 In cycles with no access, mem_we SHALL be 0 and mem_addr SHALL hold its last value.

Reset
REQ-026 While reset is high, the block SHALL force FSM = IDLE; cpu_ack, cpu_rvalid, mem_we, frame_start = 0; rgb, cpu_rdata, mem_addr, mem_wdata, drop_cnt = 0; h_sync, v_sync = 1; and SHALL clear all pipeline stages.
REQ-027 Reset asserted mid-access SHALL cancel any pending cpu_rvalid; an unacked request SHALL be neither acked nor issued, and the requester re-presents it.

Structure
REQ-028 The shared package SHALL hold the timing constants (H_ACTIVE, V_ACTIVE, FB_W, FB_H, PIX_W), the FB address width (17), and the CPU FSM state encoding.
REQ-029 The block SHALL contain one sub-module, fb_addr_calc (registered x/y to linear address), with the arbiter FSM and the delay pipelines kept in the top level.

Verification
REQ-030 Reset with syncs idle -> all outputs match REQ-026 on the first post-reset cycle.
REQ-031 RAM preloaded with addr 0 = 0xF00 and addr 1 = 0x0F0; h_cnt 0..3 at v_cnt 0 -> rgb shows 0xF00, 0xF00, 0x0F0, 0x0F0 in cycles t+3..t+6, and h_sync/v_sync track the inputs delayed by 3 cycles.
REQ-032 cpu_req write to addr 100 with data 0xABC raised in a display slot -> cpu_ack 2 cycles later, mem_we = 1 and mem_addr = 100 in the ack cycle; a later read of 100 returns 0xABC with cpu_rvalid 2 cycles after its ack.
REQ-033 cpu_req held high continuously during blanking with addr updated on each ack -> acks every 2 cycles and never two consecutive.
REQ-034 Write to addr 76800, then 300 further out-of-range writes -> mem_we stays 0, every request is acked, drop_cnt reaches 255 and holds.
REQ-035 Reset pulsed in the cycle after a read ack -> no cpu_rvalid is produced and the FSM resumes in IDLE.

Source files
------------

// File: rtl/vga_fb_arbiter_pkg.sv
// rtl/vga_fb_arbiter_pkg.sv - shared timing constants, address width and CPU FSM encoding
package vga_fb_arbiter_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int FB_W     = 320;
    localparam int FB_H     = 240;
    localparam int PIX_W    = 12;
    localparam int FB_AW    = 17;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } cpu_state_e;

endpackage

// File: rtl/fb_addr_calc.sv
// rtl/fb_addr_calc.sv - frame-buffer x/y (from the registered timing counters) to linear address
module fb_addr_calc
    import vga_fb_arbiter_pkg::*;
(
    input  logic [8:0]       x,
    input  logic [8:0]       y,
    output logic [FB_AW-1:0] addr
);

    logic [FB_AW-1:0] y_ext;
    logic [FB_AW-1:0] x_ext;

    // y*320 + x without a multiplier: y*256 + y*64 + x
    always_comb begin
        y_ext = {8'd0, y};
        x_ext = {8'd0, x};
        addr  = (y_ext << 8) + (y_ext << 6) + x_ext;
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - shares one frame-buffer RAM port between 2x-scaled VGA scan-out and a CPU
module vga_fb_arbiter #(
    parameter int H_ACTIVE = vga_fb_arbiter_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_fb_arbiter_pkg::V_ACTIVE,
    parameter int FB_W     = vga_fb_arbiter_pkg::FB_W,
    parameter int FB_H     = vga_fb_arbiter_pkg::FB_H,
    parameter int PIX_W    = vga_fb_arbiter_pkg::PIX_W
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [9:0]                           h_cnt,
    input  logic [9:0]                           v_cnt,
    input  logic                                 h_sync_in,
    input  logic                                 v_sync_in,
    input  logic                                 cpu_req,
    input  logic                                 cpu_we,
    input  logic [vga_fb_arbiter_pkg::FB_AW-1:0] cpu_addr,
    input  logic [PIX_W-1:0]                     cpu_wdata,
    output logic                                 cpu_ack,
    output logic                                 cpu_rvalid,
    output logic [PIX_W-1:0]                     cpu_rdata,
    output logic [vga_fb_arbiter_pkg::FB_AW-1:0] mem_addr,
    output logic                                 mem_we,
    output logic [PIX_W-1:0]                     mem_wdata,
    input  logic [PIX_W-1:0]                     mem_rdata,
    output logic [PIX_W-1:0]                     rgb,
    output logic                                 h_sync,
    output logic                                 v_sync,
    output logic                                 frame_start,
    output logic [7:0]                           drop_cnt
);

    import vga_fb_arbiter_pkg::*;

    localparam logic [9:0]       H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0]       V_ACT   = 10'(V_ACTIVE);
    localparam logic [FB_AW-1:0] FB_SIZE = FB_AW'(FB_W * FB_H);

    cpu_state_e state_q, state_d;

    logic             pix_active;
    logic             disp_slot;
    logic             cpu_in_range;
    logic             grant;
    logic [FB_AW-1:0] disp_addr;

    logic [FB_AW-1:0] mem_addr_q, mem_addr_d;
    logic             mem_we_q, mem_we_d;
    logic [PIX_W-1:0] mem_wdata_q, mem_wdata_d;
    logic             rd_issue_q, rd_issue_d;
    logic             rd_data_q, rd_data_d;
    logic             cpu_rvalid_q, cpu_rvalid_d;
    logic [PIX_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             act1_q, act1_d;
    logic             act2_q, act2_d;
    logic             disp1_q, disp1_d;
    logic             disp2_q, disp2_d;
    logic [PIX_W-1:0] rgb_q, rgb_d;
    logic [2:0]       hs_q, hs_d;
    logic [2:0]       vs_q, vs_d;
    logic             frame_start_q, frame_start_d;

    fb_addr_calc u_fb_addr_calc (
        .x    (h_cnt[9:1]),
        .y    (v_cnt[9:1]),
        .addr (disp_addr)
    );

    // Even active pixels own the RAM; odd pixels reuse the fetched word, freeing the port
    always_comb begin
        pix_active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        disp_slot    = pix_active && !h_cnt[0];
        cpu_in_range = cpu_addr < FB_SIZE;
        grant        = (state_q == ST_IDLE) && cpu_req && !disp_slot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_ack = (state_q == ST_ACK);
    end

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        rd_issue_d  = 1'b0;
        drop_cnt_d  = drop_cnt_q;
        if (disp_slot) begin
            mem_addr_d = disp_addr;
        end else if (grant) begin
            mem_addr_d  = cpu_addr;
            mem_we_d    = cpu_we && cpu_in_range;
            mem_wdata_d = cpu_wdata;
            rd_issue_d  = !cpu_we && cpu_in_range;
            if (!cpu_in_range && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end

        // RAM data for a read issued in the ack cycle lands one cycle later
        rd_data_d    = rd_issue_q;
        cpu_rvalid_d = rd_data_q;
        cpu_rdata_d  = rd_data_q ? mem_rdata : cpu_rdata_q;

        act1_d  = pix_active;
        disp1_d = disp_slot;
        act2_d  = act1_q;
        disp2_d = disp1_q;
        if (!act2_q) begin
            rgb_d = '0;
        end else if (disp2_q) begin
            rgb_d = mem_rdata;
        end else begin
            rgb_d = rgb_q;
        end

        hs_d          = {hs_q[1:0], h_sync_in};
        vs_d          = {vs_q[1:0], v_sync_in};
        frame_start_d = (h_cnt == 10'd0) && (v_cnt == V_ACT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
            rd_issue_q    <= 1'b0;
            rd_data_q     <= 1'b0;
            cpu_rvalid_q  <= 1'b0;
            cpu_rdata_q   <= '0;
            drop_cnt_q    <= 8'd0;
            act1_q        <= 1'b0;
            act2_q        <= 1'b0;
            disp1_q       <= 1'b0;
            disp2_q       <= 1'b0;
            rgb_q         <= '0;
            hs_q          <= 3'b111;
            vs_q          <= 3'b111;
            frame_start_q <= 1'b0;
        end else begin
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
            rd_issue_q    <= rd_issue_d;
            rd_data_q     <= rd_data_d;
            cpu_rvalid_q  <= cpu_rvalid_d;
            cpu_rdata_q   <= cpu_rdata_d;
            drop_cnt_q    <= drop_cnt_d;
            act1_q        <= act1_d;
            act2_q        <= act2_d;
            disp1_q       <= disp1_d;
            disp2_q       <= disp2_d;
            rgb_q         <= rgb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign cpu_rvalid  = cpu_rvalid_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign drop_cnt    = drop_cnt_q;
    assign rgb         = rgb_q;
    assign h_sync      = hs_q[2];
    assign v_sync      = vs_q[2];
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed table-driven bench for vga_fb_arbiter
module tb_vga_fb_arbiter;

    logic        clk;
    logic        reset;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        h_sync_in;
    logic        v_sync_in;
    logic        cpu_req;
    logic        cpu_we;
    logic [16:0] cpu_addr;
    logic [11:0] cpu_wdata;
    logic        cpu_ack;
    logic        cpu_rvalid;
    logic [11:0] cpu_rdata;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [11:0] rgb;
    logic        h_sync;
    logic        v_sync;
    logic        frame_start;
    logic [7:0]  drop_cnt;

    int n_vec;
    int n_err;

    vga_fb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .h_sync_in   (h_sync_in),
        .v_sync_in   (v_sync_in),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .rgb         (rgb),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .frame_start (frame_start),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] ram [0:131071];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic [11:0] e_rgb;
        logic        e_hs;
        logic        e_vs;
        logic [16:0] e_addr;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input int h, input int v, input logic hs, input logic vs,
                                input int e_rgb, input logic e_hs, input logic e_vs, input int e_addr);
        vec_t r;
        r.h      = 10'(h);
        r.v      = 10'(v);
        r.hs     = hs;
        r.vs     = vs;
        r.e_rgb  = 12'(e_rgb);
        r.e_hs   = e_hs;
        r.e_vs   = e_vs;
        r.e_addr = 17'(e_addr);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic blank();
        h_cnt = 10'd700;
        v_cnt = 10'd500;
    endtask

    // Presents one request and waits (bounded) for its ack; returns at the cycle after the ack with req low
    task automatic cpu_access(input logic we, input logic [16:0] addr, input logic [11:0] wd,
                              output int lat, output logic we_seen);
        lat       = -1;
        we_seen   = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        for (int i = 0; i < 6; i++) begin
            sample();
            if (cpu_ack) begin
                lat     = i;
                we_seen = mem_we;
                step();
                break;
            end
            step();
        end
        cpu_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   lat;
        logic we_seen;
        int   n_badlat;
        int   n_we;
        int   n_rv;

        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 131072; i++) ram[i] = 12'h000;
        ram[0]   = 12'hF00;
        ram[1]   = 12'h0F0;
        ram[2]   = 12'h00F;
        ram[320] = 12'h123;
        ram[321] = 12'h456;
        ram[322] = 12'h789;

        tbl[0]  = mk(0,   0, 1, 1, 'h000, 1, 1, 0);
        tbl[1]  = mk(1,   0, 0, 1, 'h000, 1, 1, 0);
        tbl[2]  = mk(2,   0, 0, 0, 'h000, 1, 1, 0);
        tbl[3]  = mk(3,   0, 1, 0, 'hF00, 1, 1, 1);
        tbl[4]  = mk(4,   0, 1, 1, 'hF00, 0, 1, 1);
        tbl[5]  = mk(5,   0, 1, 1, 'h0F0, 0, 0, 2);
        tbl[6]  = mk(700, 0, 0, 1, 'h0F0, 1, 0, 2);
        tbl[7]  = mk(701, 0, 1, 1, 'h00F, 1, 1, 2);
        tbl[8]  = mk(0,   2, 1, 1, 'h00F, 1, 1, 2);
        tbl[9]  = mk(1,   2, 1, 1, 'h000, 0, 1, 320);
        tbl[10] = mk(2,   2, 1, 1, 'h000, 1, 1, 320);
        tbl[11] = mk(3,   2, 1, 1, 'h123, 1, 1, 321);
        tbl[12] = mk(4,   2, 1, 1, 'h123, 1, 1, 321);
        tbl[13] = mk(700, 2, 1, 1, 'h456, 1, 1, 322);
        tbl[14] = mk(701, 2, 1, 1, 'h456, 1, 1, 322);
        tbl[15] = mk(702, 2, 1, 1, 'h789, 1, 1, 322);
        tbl[16] = mk(703, 2, 1, 1, 'h000, 1, 1, 322);

        reset     = 1'b1;
        blank();
        h_sync_in = 1'b1;
        v_sync_in = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        step();
        step();
        step();
        reset = 1'b0;

        // first post-reset cycle
        sample();
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_rgb", rgb, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_h_sync", h_sync, 1);
        check("rst_v_sync", v_sync, 1);
        step();
        step();
        step();

        // scan-out vectors
        for (int k = 0; k < 17; k++) begin
            h_cnt     = tbl[k].h;
            v_cnt     = tbl[k].v;
            h_sync_in = tbl[k].hs;
            v_sync_in = tbl[k].vs;
            sample();
            check($sformatf("rgb[%0d]", k), rgb, tbl[k].e_rgb);
            check($sformatf("h_sync[%0d]", k), h_sync, tbl[k].e_hs);
            check($sformatf("v_sync[%0d]", k), v_sync, tbl[k].e_vs);
            check($sformatf("mem_addr[%0d]", k), mem_addr, tbl[k].e_addr);
            step();
        end
        blank();
        step();

        // frame_start on entry to vertical blank
        h_cnt = 10'd0;
        v_cnt = 10'd480;
        sample();
        check("fs_before", frame_start, 0);
        step();
        h_cnt = 10'd1;
        sample();
        check("fs_pulse", frame_start, 1);
        step();
        h_cnt = 10'd2;
        sample();
        check("fs_after", frame_start, 0);
        step();

        // write raised in a display slot: display wins, ack two cycles later
        h_cnt     = 10'd0;
        v_cnt     = 10'd0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 17'd100;
        cpu_wdata = 12'hABC;
        sample();
        check("wr_ack_t0", cpu_ack, 0);
        step();
        h_cnt = 10'd1;
        sample();
        check("wr_ack_t1", cpu_ack, 0);
        step();
        h_cnt = 10'd2;
        sample();
        check("wr_ack_t2", cpu_ack, 1);
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_addr", mem_addr, 100);
        check("wr_mem_wdata", mem_wdata, 12'hABC);
        step();
        h_cnt   = 10'd3;
        cpu_req = 1'b0;
        sample();
        check("wr_ack_t3", cpu_ack, 0);
        check("wr_we_t3", mem_we, 0);
        step();
        blank();
        step();

        // read back in blanking
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 17'd100;
        sample();
        check("rd_ack_t0", cpu_ack, 0);
        step();
        sample();
        check("rd_ack_t1", cpu_ack, 1);
        check("rd_we_t1", mem_we, 0);
        step();
        cpu_req = 1'b0;
        sample();
        check("rd_rvalid_a1", cpu_rvalid, 0);
        step();
        sample();
        check("rd_rvalid_a2", cpu_rvalid, 1);
        check("rd_rdata_a2", cpu_rdata, 12'hABC);
        step();
        sample();
        check("rd_rvalid_a3", cpu_rvalid, 0);
        check("rd_rdata_hold", cpu_rdata, 12'hABC);
        step();

        // continuous requests: one ack every other cycle
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 17'd200;
        cpu_wdata = 12'h001;
        for (int k = 0; k < 12; k++) begin
            sample();
            check($sformatf("b2b_ack[%0d]", k), cpu_ack, (k % 2 == 1) ? 1 : 0);
            if (cpu_ack) begin
                step();
                cpu_addr  = cpu_addr + 17'd1;
                cpu_wdata = cpu_wdata + 12'd1;
            end else begin
                step();
            end
        end
        cpu_req = 1'b0;
        step();
        step();

        // out-of-range writes: acked, never written, drop counter saturates
        n_badlat = 0;
        n_we     = 0;
        for (int i = 0; i < 301; i++) begin
            cpu_access(1'b1, 17'(76800 + i), 12'h5A5, lat, we_seen);
            if (lat != 1) n_badlat++;
            if (we_seen) n_we++;
            if (i == 99) check("drop_cnt_100", drop_cnt, 100);
        end
        check("oor_bad_ack_count", n_badlat, 0);
        check("oor_mem_we_count", n_we, 0);
        check("drop_cnt_sat", drop_cnt, 255);
        cpu_access(1'b0, 17'd76900, 12'h000, lat, we_seen);
        check("oor_rd_lat", lat, 1);
        n_rv = 0;
        for (int k = 0; k < 4; k++) begin
            sample();
            if (cpu_rvalid) n_rv++;
            step();
        end
        check("oor_rd_rvalid", n_rv, 0);
        check("drop_cnt_hold", drop_cnt, 255);

        // reset in the cycle after a read ack cancels the rvalid
        cpu_access(1'b0, 17'd100, 12'h000, lat, we_seen);
        check("rst_rd_lat", lat, 1);
        reset = 1'b1;
        sample();
        check("rstmid_rvalid_a1", cpu_rvalid, 0);
        step();
        reset = 1'b0;
        sample();
        check("rstmid_rvalid_a2", cpu_rvalid, 0);
        check("rstmid_rdata", cpu_rdata, 0);
        check("rstmid_drop_cnt", drop_cnt, 0);
        check("rstmid_ack", cpu_ack, 0);
        step();
        sample();
        check("rstmid_rvalid_a3", cpu_rvalid, 0);
        step();
        cpu_access(1'b0, 17'd100, 12'h000, lat, we_seen);
        check("post_rst_lat", lat, 1);
        sample();
        check("post_rst_rvalid_a1", cpu_rvalid, 0);
        step();
        sample();
        check("post_rst_rvalid_a2", cpu_rvalid, 1);
        check("post_rst_rdata", cpu_rdata, 12'hABC);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
